serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/slice_adder.sv | 15 +
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial slice adder: FSM encoding and default sizing.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/slice_adder.sv
// One WIDTH-bit ripple slice: the only arithmetic unit in the serial adder.
module slice_adder #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  // The extra top bit of the widened sum is the carry out of the slice.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule : slice_adder

// File: rtl/serial_add_ctrl.sv
// Serial adder: sums two WIDTH*WORDS operands one WIDTH-bit slice per cycle,
// least significant slice first, and presents a registered result with a
// one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [N-1:0]     a_q, b_q;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     sum_q;
  logic             cout_q;

  logic [WIDTH-1:0] a_sl, b_sl;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Select the captured operand slices addressed by idx (constant-offset mux).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_sl = a_q[k*WIDTH +: WIDTH];
        b_sl = b_q[k*WIDTH +: WIDTH];
      end
    end
  end

  slice_adder #(.WIDTH(WIDTH)) u_slice_adder (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Accumulator with the current adder result merged into slice idx.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        acc_d[k*WIDTH +: WIDTH] = add_sum;
      end
    end
  end

  // Control FSM and datapath registers; result registers update only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulator and operand copies are plain flops, not a RAM, so
    // they are cleared by reset like every other state bit.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop sees
      // pre-edge values regardless of statement order.
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            sum_q   <= acc_d;
            cout_q  <= add_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule : serial_add_ctrl
